// File: rtl/ext_sbit_pkg.sv
// Shared types and helpers for the external S-bit receiver.
// Holds the default line count, the FSM state type and a popcount helper.
package ext_sbit_pkg;

   localparam int SBIT_NUM_LINES = 8;

   // popcount input is sized to cover any sensible line count
   localparam int POP_MAX_LINES = 16;
   localparam int POP_W = $clog2(POP_MAX_LINES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      DEAD = 2'd2
   } sbit_state_e;

   function automatic logic [POP_W-1:0] popcount(
      input logic [POP_MAX_LINES-1:0] v
   );
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < POP_MAX_LINES; i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/ext_sbit_line.sv
// One external S-bit line: 2-FF synchroniser, rising-edge register and
// saturating rate counter (clear wins over increment).
// Ports: clock, reset_i (async, active-high), sbit_i (async level),
//   cnt_reset_i (sync clear), sync_o (synced level), edge_o (edge pulse),
//   cnt_o (rate counter).
module ext_sbit_line #(
   parameter int CNT_WIDTH = 24
) (
   input  logic                 clock,
   input  logic                 reset_i,
   input  logic                 sbit_i,
   input  logic                 cnt_reset_i,
   output logic                 sync_o,
   output logic                 edge_o,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   logic                 meta_q;
   logic                 sync_q;
   logic                 prev_q;
   logic                 edge_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_reset_i) begin
         cnt_d = '0;
      end else if (edge_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= sbit_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         edge_q <= sync_q & ~prev_q;
         cnt_q  <= cnt_d;
      end
   end

   assign sync_o = sync_q;
   assign edge_o = edge_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/ext_sbit_receiver.sv
// Receive end of the 8-line external S-bit interface: per-line sync,
// edge detect and rate counters, plus majority trigger with dead time.
// Ports: clock, reset_i (async, active-high), ext_sbits_i, line_en_i,
//   majority_i, deadtime_i, cnt_reset_i, sync_sbits_o, trigger_o,
//   trigger_lines_o, rate_cnt_o, and veto_cnt_o when
//   EXT_SBIT_VETO_CNT_EN is defined (counts discarded candidates).
module ext_sbit_receiver
   import ext_sbit_pkg::*;
#(
   parameter int NUM_LINES      = SBIT_NUM_LINES,
   parameter int CNT_WIDTH      = 24,
   parameter int DEADTIME_WIDTH = 8
) (
   input  logic                           clock,
   input  logic                           reset_i,
   input  logic [NUM_LINES-1:0]           ext_sbits_i,
   input  logic [NUM_LINES-1:0]           line_en_i,
   input  logic [3:0]                     majority_i,
   input  logic [DEADTIME_WIDTH-1:0]      deadtime_i,
   input  logic                           cnt_reset_i,
   output logic [NUM_LINES-1:0]           sync_sbits_o,
   output logic                           trigger_o,
   output logic [NUM_LINES-1:0]           trigger_lines_o,
   output logic [NUM_LINES*CNT_WIDTH-1:0] rate_cnt_o
`ifdef EXT_SBIT_VETO_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]           veto_cnt_o
`endif
);

   logic [NUM_LINES-1:0]      edge_w;
   logic [NUM_LINES-1:0]      masked_w;
   logic [POP_W-1:0]          hits_w;
   logic                      cand_w;

   sbit_state_e               state_q;
   sbit_state_e               state_d;
   logic [DEADTIME_WIDTH-1:0] dead_q;
   logic [DEADTIME_WIDTH-1:0] dead_d;
   logic [NUM_LINES-1:0]      lines_q;
   logic [NUM_LINES-1:0]      lines_d;

   for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
      ext_sbit_line #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_line (
         .clock       (clock),
         .reset_i     (reset_i),
         .sbit_i      (ext_sbits_i[k]),
         .cnt_reset_i (cnt_reset_i),
         .sync_o      (sync_sbits_o[k]),
         .edge_o      (edge_w[k]),
         .cnt_o       (rate_cnt_o[k*CNT_WIDTH +: CNT_WIDTH])
      );
   end

   assign masked_w = edge_w & line_en_i;
   assign hits_w   = popcount(POP_MAX_LINES'(masked_w));

   // majority 0 would otherwise trigger on every cycle
   assign cand_w = (majority_i != 4'd0) &&
                   (hits_w >= POP_W'(majority_i));

   always_comb begin
      state_d = state_q;
      dead_d  = dead_q;
      lines_d = lines_q;
      unique case (state_q)
         IDLE: begin
            if (cand_w) begin
               state_d = FIRE;
               lines_d = masked_w;
            end
         end
         FIRE: begin
            dead_d  = deadtime_i;
            state_d = (deadtime_i != '0) ? DEAD : IDLE;
         end
         DEAD: begin
            dead_d = dead_q - DEADTIME_WIDTH'(1);
            if (dead_q <= DEADTIME_WIDTH'(1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         dead_q  <= '0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         dead_q  <= dead_d;
         lines_q <= lines_d;
      end
   end

   assign trigger_o       = (state_q == FIRE);
   assign trigger_lines_o = lines_q;

`ifdef EXT_SBIT_VETO_CNT_EN
   logic [CNT_WIDTH-1:0] veto_q;
   logic [CNT_WIDTH-1:0] veto_d;

   always_comb begin
      veto_d = veto_q;
      if (cnt_reset_i) begin
         veto_d = '0;
      end else if (cand_w && (state_q != IDLE) &&
                   (veto_q != '1)) begin
         veto_d = veto_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         veto_q <= '0;
      end else begin
         veto_q <= veto_d;
      end
   end

   assign veto_cnt_o = veto_q;
`endif

endmodule

// File: tb/tb_ext_sbit_receiver.sv
// Directed bench for ext_sbit_receiver built with 4-bit counters so
// saturation is reachable; veto counter checked when the macro is set.
module tb_ext_sbit_receiver;

   localparam int NL = 8;
   localparam int CW = 4;
   localparam int DW = 8;

   logic             clock;
   logic             reset_i;
   logic [NL-1:0]    ext_sbits;
   logic [NL-1:0]    line_en;
   logic [3:0]       majority;
   logic [DW-1:0]    deadtime;
   logic             cnt_reset;
   logic [NL-1:0]    sync_sbits;
   logic             trigger;
   logic [NL-1:0]    trig_lines;
   logic [NL*CW-1:0] rate_cnt;
`ifdef EXT_SBIT_VETO_CNT_EN
   logic [CW-1:0]    veto_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int trig_q[$];
   int base;

   ext_sbit_receiver #(
      .NUM_LINES      (NL),
      .CNT_WIDTH      (CW),
      .DEADTIME_WIDTH (DW)
   ) dut (
      .clock           (clock),
      .reset_i         (reset_i),
      .ext_sbits_i     (ext_sbits),
      .line_en_i       (line_en),
      .majority_i      (majority),
      .deadtime_i      (deadtime),
      .cnt_reset_i     (cnt_reset),
      .sync_sbits_o    (sync_sbits),
      .trigger_o       (trigger),
      .trigger_lines_o (trig_lines),
      .rate_cnt_o      (rate_cnt)
`ifdef EXT_SBIT_VETO_CNT_EN
      ,
      .veto_cnt_o      (veto_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // record the cycle number of every trigger pulse
   always @(posedge clock) begin
      cyc = cyc + 1;
      if (trigger === 1'b1) trig_q.push_back(cyc);
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h",
                  tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic [NL-1:0] v,
                        input int hi, input int lo);
      ext_sbits = v;
      repeat (hi) tick();
      ext_sbits = '0;
      repeat (lo) tick();
   endtask

   task automatic clr_cnt();
      cnt_reset = 1'b1;
      tick();
      cnt_reset = 1'b0;
   endtask

   initial begin
      reset_i   = 1'b1;
      ext_sbits = '0;
      line_en   = 8'hFF;
      majority  = 4'd1;
      deadtime  = '0;
      cnt_reset = 1'b0;
      tick();
      tick();
      chk("rst_trig",  64'(trigger),    64'h0);
      chk("rst_lines", 64'(trig_lines), 64'h0);
      chk("rst_rate",  64'(rate_cnt),   64'h0);
      chk("rst_sync",  64'(sync_sbits), 64'h0);
      reset_i = 1'b0;
      tick();

      // single pulse on line 3, latency check
      base = trig_q.size();
      ext_sbits = 8'h08;
      tick();
      tick();
      chk("t1_sync",  64'(sync_sbits), 64'h08);
      tick();
      chk("t1_e3",    64'(trigger),    64'h0);
      tick();
      chk("t1_e4",    64'(trigger),    64'h1);
      chk("t1_lines", 64'(trig_lines), 64'h08);
      tick();
      chk("t1_e5",    64'(trigger),    64'h0);
      ext_sbits = '0;
      repeat (6) tick();
      chk("t1_ntrig", 64'(trig_q.size() - base), 64'd1);
      chk("t1_rate",  64'(rate_cnt), 64'h0000_1000);

      // majority of 3
      majority = 4'd3;
      base = trig_q.size();
      pulse(8'h07, 3, 6);
      chk("t2_ntrig", 64'(trig_q.size() - base), 64'd1);
      chk("t2_lines", 64'(trig_lines), 64'h07);
      chk("t2_rate",  64'(rate_cnt), 64'h0000_1111);
      line_en = 8'hFB;
      base = trig_q.size();
      pulse(8'h07, 3, 6);
      chk("t2_mask_ntrig", 64'(trig_q.size() - base), 64'd0);
      chk("t2_mask_lines", 64'(trig_lines), 64'h07);
      chk("t2_mask_rate",  64'(rate_cnt), 64'h0000_1222);

      // dead time 10, edge every 4 cycles
      line_en  = 8'hFF;
      majority = 4'd1;
      deadtime = 8'd10;
      clr_cnt();
      chk("t3_clr", 64'(rate_cnt), 64'h0);
      base = trig_q.size();
      for (int i = 0; i < 12; i++) pulse(8'h01, 2, 2);
      repeat (16) tick();
      chk("t3_ntrig", 64'(trig_q.size() - base), 64'd4);
      chk("t3_sp1",
          64'(trig_q[base+1] - trig_q[base]), 64'd12);
      chk("t3_sp3",
          64'(trig_q[base+3] - trig_q[base]), 64'd36);
      chk("t3_rate", 64'(rate_cnt), 64'h0000_000C);
`ifdef EXT_SBIT_VETO_CNT_EN
      chk("t3_veto", 64'(veto_cnt), 64'd8);
`endif
      deadtime = '0;
      clr_cnt();
`ifdef EXT_SBIT_VETO_CNT_EN
      chk("t3_veto_clr", 64'(veto_cnt), 64'd0);
`endif
      base = trig_q.size();
      for (int i = 0; i < 4; i++) pulse(8'h01, 2, 2);
      repeat (8) tick();
      chk("t3_dt0_ntrig", 64'(trig_q.size() - base), 64'd4);
      chk("t3_dt0_sp",
          64'(trig_q[base+1] - trig_q[base]), 64'd4);
      chk("t3_dt0_rate", 64'(rate_cnt), 64'h0000_0004);
`ifdef EXT_SBIT_VETO_CNT_EN
      chk("t3_dt0_veto", 64'(veto_cnt), 64'd0);
`endif

      // saturation on line 7, then clear racing an edge
      clr_cnt();
      for (int i = 0; i < 19; i++) pulse(8'h80, 2, 2);
      repeat (6) tick();
      chk("t4_sat", 64'(rate_cnt), 64'hF000_0000);
      ext_sbits = 8'h80;
      tick();
      tick();
      tick();
      cnt_reset = 1'b1;
      tick();
      cnt_reset = 1'b0;
      chk("t4_clr_pri", 64'(rate_cnt), 64'h0);
      repeat (3) tick();
      ext_sbits = '0;
      repeat (4) tick();
      chk("t4_clr_hold", 64'(rate_cnt), 64'h0);

      // majority boundaries
      majority = 4'd0;
      base = trig_q.size();
      pulse(8'hFF, 3, 6);
      chk("t5_m0_ntrig", 64'(trig_q.size() - base), 64'd0);
      chk("t5_m0_rate",  64'(rate_cnt), 64'h1111_1111);
      majority = 4'd9;
      pulse(8'hFF, 3, 6);
      chk("t5_m9_ntrig", 64'(trig_q.size() - base), 64'd0);
      chk("t5_m9_rate",  64'(rate_cnt), 64'h2222_2222);
      majority = 4'd8;
      pulse(8'hFF, 3, 6);
      chk("t5_m8_ntrig", 64'(trig_q.size() - base), 64'd1);
      chk("t5_m8_lines", 64'(trig_lines), 64'hFF);
      chk("t5_m8_rate",  64'(rate_cnt), 64'h3333_3333);

      // async reset glitch inside DEAD
      majority = 4'd1;
      deadtime = 8'd10;
      ext_sbits = 8'h10;
      repeat (4) tick();
      chk("t6_fire", 64'(trigger), 64'h1);
      repeat (3) tick();
      #2;
      reset_i = 1'b1;
      #1;
      chk("t6_rst_trig",  64'(trigger),    64'h0);
      chk("t6_rst_lines", 64'(trig_lines), 64'h0);
      chk("t6_rst_rate",  64'(rate_cnt),   64'h0);
      chk("t6_rst_sync",  64'(sync_sbits), 64'h0);
`ifdef EXT_SBIT_VETO_CNT_EN
      chk("t6_rst_veto",  64'(veto_cnt),   64'h0);
`endif
      reset_i = 1'b0;
      tick();
      tick();
      chk("t6_sync", 64'(sync_sbits), 64'h10);
      tick();
      chk("t6_e3", 64'(trigger), 64'h0);
      tick();
      chk("t6_e4",    64'(trigger),    64'h1);
      chk("t6_lines", 64'(trig_lines), 64'h10);
      chk("t6_rate",  64'(rate_cnt),   64'h0001_0000);
      ext_sbits = '0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ext_sbit_receiver.md
Name: ext_sbit_receiver

Overview:
- Receive end of the 8-line external (HDMI) S-bit interface driven by the OptoHybrid.
- Sits on the test-stand or trigger-board FPGA.
- Synchronises the 8 asynchronous level inputs and detects rising edges.
- Keeps per-line saturating rate counters and fires a majority-coincidence trigger with programmable dead time.

Parameters:
- NUM_LINES, 8, number of external S-bit lines.
- CNT_WIDTH, 24, width of each per-line rate counter.
- DEADTIME_WIDTH, 8, width of the dead-time setting.

Ports:
- clock  in  1  fabric clock (40 MHz LHC clock domain).
- reset_i  in  1  asynchronous, active-high reset.
- ext_sbits_i  in  NUM_LINES  raw HDMI S-bit levels, asynchronous to clock.
- line_en_i  in  NUM_LINES  per-line coincidence enable (1 = participates).
- majority_i  in  4  minimum number of simultaneous enabled edges needed to trigger.
- deadtime_i  in  DEADTIME_WIDTH  dead cycles after each trigger.
- cnt_reset_i  in  1  synchronous clear of all rate counters.
- sync_sbits_o  out  NUM_LINES  synchronised line levels.
- trigger_o  out  1  single-cycle coincidence trigger pulse.
- trigger_lines_o  out  NUM_LINES  enabled edge pattern captured at the last trigger.
- rate_cnt_o  out  NUM_LINES*CNT_WIDTH  per-line edge counters; line k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- Reset: reset_i is asynchronous and active-high. It clears the synchronisers, edge registers, counters, FSM (to IDLE), trigger_o, trigger_lines_o and sync_sbits_o to 0. Reset is effective mid-operation at any point, including inside DEAD.
- Synchroniser: 2 flip-flops per line; sync_sbits_o is the second stage.
- Edge detect: edge_r[k] registered from sync[k] & ~sync_d[k]. A line held high produces one edge only.
- Latency: the first clock edge sampling ext_sbits_i high is edge 1. edge_r is set at edge 3. trigger_o and the counter increment occur at edge 4.
- Counters:
  - Each counter increments by 1 on edge_r[k], regardless of line_en_i or FSM state.
  - Counters saturate at all-ones and do not wrap.
  - cnt_reset_i has priority over an increment in the same cycle.
- Coincidence: hits = popcount(edge_r & line_en_i). A trigger candidate requires majority_i != 0 and hits >= majority_i.
  - majority_i = 0 never triggers.
  - majority_i > NUM_LINES never triggers.
- FSM states:
  - IDLE: on a candidate, go to FIRE and latch trigger_lines_o <= edge_r & line_en_i.
  - FIRE: trigger_o = 1 for exactly this cycle. Load the dead counter with deadtime_i. Go to DEAD if deadtime_i != 0, otherwise to IDLE.
  - DEAD: decrement each cycle; go to IDLE when the counter reaches 1. Candidates in FIRE and DEAD are discarded, not queued.
- deadtime_i is sampled once, in FIRE; changes during DEAD do not take effect until the next trigger. line_en_i and majority_i are used combinationally each cycle.
- trigger_lines_o holds its value until the next trigger.

Optional Feature:
- Macro: EXT_SBIT_VETO_CNT_EN.
- When defined:
  - Adds output veto_cnt_o (CNT_WIDTH).
  - It counts trigger candidates discarded in FIRE or DEAD, saturating at all-ones.
  - It is cleared by cnt_reset_i and by reset_i.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ext_sbit_pkg holds:
  - NUM_LINES default;
  - FSM state enum (IDLE, FIRE, DEAD);
  - popcount function of width NUM_LINES.
- Sub-module ext_sbit_line, instantiated per line, contains:
  - 2-FF synchroniser;
  - edge register;
  - saturating counter with cnt_reset_i priority.
- Coincidence logic and FSM stay in the top.

Test Plan:
1. Single pulse: line 3 goes high for 5 cycles, line_en_i=8'hFF, majority_i=1 -> trigger_o pulses once at edge 4; trigger_lines_o=8'h08; rate_cnt[3]=1; other counters 0.
2. Majority: lines 0, 1, 2 rise together, majority_i=3 -> one trigger with trigger_lines_o=8'h07. Repeat with line_en_i=8'hFB -> no trigger, but counters 0, 1, 2 still increment.
3. Dead time: deadtime_i=10, line 0 toggles every 4 cycles with majority_i=1 -> triggers spaced 12 cycles apart (FIRE + 10 DEAD + IDLE detect). With EXT_SBIT_VETO_CNT_EN defined, veto_cnt_o increments for each discarded edge. With deadtime_i=0, every edge triggers.
4. Saturation: force 2^CNT_WIDTH+3 edges on line 7 (CNT_WIDTH=4 build: 19 edges) -> rate_cnt[7]=4'hF. Assert cnt_reset_i in the same cycle as an edge -> counter reads 0.
5. Boundaries: majority_i=0 and majority_i=9 with all lines pulsing -> trigger_o never asserts, counters still count.
6. Async reset: assert reset_i mid-DEAD for a sub-cycle glitch -> all outputs 0 immediately without a clock edge. After release, a new edge triggers normally with 4-cycle latency.
